// File: rtl/scan_ctrl_pkg.sv
// scan_ctrl_pkg: shared FSM states and default geometry for the scan chain sequencer
package scan_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT, DONE, ERR} state_t;
  localparam int DEF_NUM_DESIGNS = 4;
  localparam int DEF_NUM_IOS = 8;
  localparam int DEF_CLK_DIV = 2;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/scan_clk_gen.sv
// scan_clk_gen: period-phase counter producing a registered scan clock and phase strobes
module scan_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clk_en,
  output logic scan_clk,
  output logic high,
  output logic fall,
  output logic sample,
  output logic period_end
);
  localparam int PW = $clog2(2*CLK_DIV);
  logic [PW-1:0] ph;
  assign sample = run && ph == PW'(CLK_DIV-1);
  assign period_end = run && ph == PW'(2*CLK_DIV-1);
  assign fall = period_end && scan_clk;
  // clk_en is captured at the rise so a gated period never produces a partial pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ph <= '0;
      high <= 1'b0;
      scan_clk <= 1'b0;
    end else if (!run) begin
      ph <= '0;
      high <= 1'b0;
      scan_clk <= 1'b0;
    end else begin
      ph <= period_end ? '0 : ph + 1'b1;
      high <= sample ? 1'b1 : period_end ? 1'b0 : high;
      scan_clk <= sample ? clk_en : period_end ? 1'b0 : scan_clk;
    end
endmodule

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: runs shift-in, latch, capture and shift-out over the shared design scan chain
module scan_chain_ctrl import scan_ctrl_pkg::*; #(
  parameter int NUM_DESIGNS = DEF_NUM_DESIGNS,
  parameter int NUM_IOS = DEF_NUM_IOS,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic start,
  input  logic [sel_w(NUM_DESIGNS)-1:0] design_sel,
  input  logic [NUM_IOS-1:0] inputs,
  output logic [NUM_IOS-1:0] outputs,
  output logic busy,
  output logic done,
  output logic sel_err,
  output logic scan_clk,
  output logic scan_data_out,
  output logic scan_select,
  output logic scan_latch_en,
  input  logic scan_data_in
);
  localparam int TOTAL = NUM_DESIGNS*NUM_IOS;
  localparam int SW = sel_w(NUM_DESIGNS);
  localparam int CW = $clog2(TOTAL+1);
  state_t state, state_nx;
  logic [SW-1:0] sel_q;
  logic [TOTAL-1:0] vec;
  logic [NUM_IOS-1:0] shadow;
  logic [CW-1:0] cnt;
  logic clk_en, high, fall, sample, period_end, last, sel_ok, hit;
  assign sel_ok = int'(design_sel) < NUM_DESIGNS;
  assign last = cnt == CW'(TOTAL-1);
  // sample k reads position TOTAL-1-k, so the selected slot spans a contiguous run of k
  assign hit = int'(cnt)/NUM_IOS == NUM_DESIGNS-1-int'(sel_q);
  assign scan_data_out = vec[TOTAL-1];
  scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .run(busy),
    .clk_en(clk_en),
    .scan_clk(scan_clk),
    .high(high),
    .fall(fall),
    .sample(sample),
    .period_end(period_end)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = start ? (sel_ok ? SHIFT_IN : ERR) : IDLE;
      SHIFT_IN:  state_nx = fall && last ? LATCH : SHIFT_IN;
      LATCH:     state_nx = period_end ? CAPTURE : LATCH;
      CAPTURE:   state_nx = fall ? SHIFT_OUT : CAPTURE;
      SHIFT_OUT: state_nx = period_end && last ? DONE : SHIFT_OUT;
      default:   state_nx = IDLE;
    endcase
    busy = state inside {SHIFT_IN, LATCH, CAPTURE, SHIFT_OUT};
    done = state == DONE || state == ERR;
    clk_en = state != LATCH;
    scan_select = state == CAPTURE;
    scan_latch_en = state == LATCH && high;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      state <= IDLE;
      sel_q <= '0;
      vec <= '0;
      shadow <= '0;
      outputs <= '0;
      cnt <= '0;
      sel_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state_nx != state ? '0 : period_end ? cnt + 1'b1 : cnt;
      if (state == IDLE && start) begin
        sel_q <= design_sel;
        sel_err <= !sel_ok;
        if (sel_ok) vec <= TOTAL'(inputs) << (int'(design_sel)*NUM_IOS);
      end
      // the vector drains to zero during SHIFT_IN, which keeps data_out low afterwards
      if (state == SHIFT_IN && fall) vec <= vec << 1;
      if (state == SHIFT_OUT && sample && hit) shadow <= NUM_IOS'({shadow, scan_data_in});
      if (state == SHIFT_OUT && state_nx == DONE) outputs <= shadow;
    end
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: two configurations, each with a behavioural chain model and a done-driven scoreboard
module tb_scan_chain_ctrl;
  typedef struct {
    logic [7:0] out;
    logic [63:0] lat;
    logic err;
    int t0;
  } exp_t;
  logic clk = 1'b0;
  int cyc = 0;
  int vec_n = 0;
  int bad_n = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int ND = g ? 3 : 4;
    localparam int CD = g ? 1 : 2;
    localparam int NI = 8;
    localparam int TOT = ND*NI;
    localparam int LAT = (2*TOT+2)*2*CD+1;
    localparam int ABORT_AT = g ? 40 : 100;
    logic rst, start, busy, done, sel_err, scan_clk, sdo, ssel, slat, sdi;
    logic [1:0] dsel;
    logic [NI-1:0] din, dout;
    logic [TOT-1:0] chain = '0;
    logic [TOT-1:0] latv = '0;
    logic [7:0] m_out = '0;
    logic [63:0] m_lat = '0;
    logic fin = 1'b0;
    logic prev_sc = 1'b0;
    logic seen_lat = 1'b0;
    int bcnt = 0, in_r = 0, cap_r = 0, out_r = 0, lat_c = 0, lat_bad = 0;
    exp_t q[$];
    scan_chain_ctrl #(.NUM_DESIGNS(ND), .NUM_IOS(NI), .CLK_DIV(CD)) dut (
      .wb_clk_i(clk),
      .wb_rst_i(rst),
      .start(start),
      .design_sel(dsel),
      .inputs(din),
      .outputs(dout),
      .busy(busy),
      .done(done),
      .sel_err(sel_err),
      .scan_clk(scan_clk),
      .scan_data_out(sdo),
      .scan_select(ssel),
      .scan_latch_en(slat),
      .scan_data_in(sdi)
    );
    // designs drive outputs = latched inputs ^ 8'hFF
    assign sdi = chain[TOT-1];
    always @(posedge scan_clk) chain <= ssel ? ~latv : {chain[TOT-2:0], sdo};
    always @(negedge clk) if (slat) latv <= chain;
    always @(negedge clk) begin : mon
      exp_t e;
      if (rst || done) begin
        if (done && !rst) begin
          if (q.size() == 0) begin
            vec_n++;
            bad_n++;
            $display("FAIL u%0d unexpected_done: got done=1 expected no done at cycle %0d", g, cyc);
          end else begin
            e = q.pop_front();
            chk($sformatf("u%0d outputs", g), 64'(dout), 64'(e.out));
            chk($sformatf("u%0d sel_err", g), 64'(sel_err), 64'(e.err));
            chk($sformatf("u%0d latency", g), 64'(cyc - e.t0), e.err ? 64'd1 : 64'(LAT));
            chk($sformatf("u%0d busy_cycles", g), 64'(bcnt), e.err ? 64'd0 : 64'(LAT-1));
            chk($sformatf("u%0d latched_slots", g), 64'(latv), e.lat);
            chk($sformatf("u%0d rises_shift_in", g), 64'(in_r), e.err ? 64'd0 : 64'(TOT));
            chk($sformatf("u%0d latch_cycles", g), 64'(lat_c), e.err ? 64'd0 : 64'(CD));
            chk($sformatf("u%0d latch_with_clk", g), 64'(lat_bad), 64'd0);
            chk($sformatf("u%0d rises_capture", g), 64'(cap_r), e.err ? 64'd0 : 64'd1);
            chk($sformatf("u%0d rises_shift_out", g), 64'(out_r), e.err ? 64'd0 : 64'(TOT));
          end
        end
        bcnt = 0; in_r = 0; cap_r = 0; out_r = 0; lat_c = 0; lat_bad = 0; seen_lat = 1'b0;
      end else begin
        if (busy) bcnt++;
        if (scan_clk && !prev_sc) begin
          if (ssel) cap_r++;
          else if (seen_lat) out_r++;
          else in_r++;
        end
        if (slat) begin
          lat_c++;
          seen_lat = 1'b1;
          if (scan_clk) lat_bad++;
        end
      end
      prev_sc = scan_clk;
    end
    task automatic issue(input int s, input logic [7:0] v, input bit push);
      exp_t e;
      @(negedge clk);
      start = 1'b1;
      dsel = 2'(s);
      din = v;
      if (push) begin
        if (s < ND) begin
          m_lat = 64'(v) << (s*NI);
          m_out = v ^ 8'hFF;
        end
        e.out = m_out;
        e.lat = m_lat;
        e.err = s >= ND;
        e.t0 = cyc;
        q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
    endtask
    task automatic wait_done();
      int n = 0;
      while (q.size() != 0 && n < LAT + 20) begin
        @(negedge clk);
        n++;
      end
      if (q.size() != 0) begin
        vec_n++;
        bad_n++;
        $display("FAIL u%0d timeout: got no done after %0d cycles expected one within %0d", g, n, LAT);
        q.delete();
      end
    endtask
    initial begin
      rst = 1'b1;
      start = 1'b0;
      dsel = '0;
      din = '0;
      repeat (3) @(negedge clk);
      chk($sformatf("u%0d reset_pins", g), 64'({dout, busy, done, sel_err, scan_clk, sdo, ssel, slat}), 64'd0);
      rst = 1'b0;
      issue(2, 8'hA5, 1); wait_done();
      issue(0, 8'h01, 1); wait_done();
      issue(ND-1, 8'h80, 1); wait_done();
      issue(3, 8'h3C, 1); wait_done();
      issue(1, 8'hC3, 1);
      repeat (48) @(negedge clk);
      issue(2, 8'hFF, 0);
      wait_done();
      issue(2, 8'h5A, 0);
      repeat (ABORT_AT - 1) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk($sformatf("u%0d abort_pins", g), 64'({dout, busy, done, sel_err, scan_clk, sdo, ssel, slat}), 64'd0);
      m_out = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      issue(1, 8'h96, 1); wait_done();
      repeat (6) begin
        issue(int'($urandom_range(0, 3)), 8'($urandom), 1);
        wait_done();
      end
      repeat (3) @(negedge clk);
      fin = 1'b1;
    end
  end
  initial begin
    for (int i = 0; i < 20000 && !(u[0].fin && u[1].fin); i++) @(negedge clk);
    if (!(u[0].fin && u[1].fin)) begin
      vec_n++;
      bad_n++;
      $display("FAIL global_timeout: got unfinished stimulus expected completion within 20000 cycles");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad_n);
    $finish;
  end
endmodule
